psram_line_fetcher: RTL and testbench

- Sits between the psram controller and the pixel colour mux, in the clk_100mhz domain.
- Reads one scanline of 16-bit pixel words from PSRAM into a ping-pong line buffer, one line ahead of display.
- The pixel path reads the display bank while the other bank is filled for the next line.
- Each word holds a 12-bit RGB444 colour in bits [11:0]; bits [15:12] are reserved and stored as-is.

---
 rtl/psram_line_fetcher.sv | 167 ++++++++++++++++
 tb/tb_psram_line_fetcher.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_line_fetcher.sv
// Fetches one scanline of pixel words from PSRAM into a ping-pong line buffer, one line ahead
// of display; the pixel path reads the display bank while the other bank fills.
module psram_line_fetcher #(
    parameter int unsigned WORDS_PER_LINE = 320,
    parameter logic [23:0] BASE_ADDR      = 24'h000000,
    parameter int unsigned LINE_STRIDE    = 640
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_line_start,
    input  logic [8:0]  i_line_index,
    input  logic        i_clr_err,
    output logic        o_psram_stb,
    output logic        o_psram_we,
    output logic [23:0] o_psram_addr,
    input  logic        i_psram_busy,
    input  logic        i_psram_done,
    input  logic [15:0] i_psram_dout,
    input  logic [9:0]  i_rd_addr,
    output logic [15:0] o_rd_data,
    output logic        o_fetching,
    output logic        o_line_ready,
    output logic        o_underrun
);

    localparam int unsigned MemDepth = 2 * WORDS_PER_LINE;
    localparam int unsigned MemAw    = $clog2(MemDepth);
    localparam logic [9:0]  LastWord = 10'(WORDS_PER_LINE - 1);
    localparam logic [15:0] Stride   = 16'(LINE_STRIDE);
    localparam logic [10:0] BankOfs  = 11'(WORDS_PER_LINE);

    typedef enum logic [1:0] {StIdle, StArm, StReq, StWait} state_e;

    state_e      state_q, state_d;
    logic        disp_bank_q, disp_bank_d;
    logic        fetch_bank_q, fetch_bank_d;
    logic [23:0] addr_q, addr_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [8:0]  pend_idx_q, pend_idx_d;
    logic        underrun_q, underrun_d;
    logic        line_ready_q, line_ready_d;
    logic [15:0] rd_data_q, rd_data_d;

    logic [15:0] buf_mem [MemDepth];

    logic             last_done;
    logic             start_go;
    logic [8:0]       start_idx;
    logic [23:0]      line_ofs;
    logic             wr_en;
    logic [MemAw-1:0] wr_idx;
    logic [MemAw-1:0] rd_idx;
    logic             rd_in_range;

    assign last_done = (state_q == StWait) && i_psram_done && (cnt_q == LastWord);
    // A start deferred from a busy period is serviced on the first idle cycle.
    assign start_go  = (state_q == StIdle) && (i_line_start || pend_q);
    assign start_idx = i_line_start ? i_line_index : pend_idx_q;
    assign line_ofs  = {15'd0, start_idx} * {8'd0, Stride};

    assign wr_en       = (state_q == StWait) && i_psram_done;
    assign wr_idx      = MemAw'({1'b0, cnt_q} + (fetch_bank_q ? BankOfs : 11'd0));
    assign rd_idx      = MemAw'({1'b0, i_rd_addr} + (disp_bank_q ? BankOfs : 11'd0));
    assign rd_in_range = {1'b0, i_rd_addr} < BankOfs;

    always_comb begin
        state_d      = state_q;
        disp_bank_d  = disp_bank_q;
        fetch_bank_d = fetch_bank_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_idx_d   = pend_idx_q;
        underrun_d   = underrun_q;
        line_ready_d = last_done;
        rd_data_d    = rd_in_range ? buf_mem[rd_idx] : 16'h0000;

        if (i_clr_err) begin
            underrun_d = 1'b0;
        end
        // A start colliding with the final done is a normal back-to-back line, not an underrun.
        if (i_line_start && (state_q != StIdle)) begin
            pend_d     = 1'b1;
            pend_idx_d = i_line_index;
            if (!last_done) begin
                underrun_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_go) begin
                    disp_bank_d  = ~disp_bank_q;
                    fetch_bank_d = ~fetch_bank_q;
                    addr_d       = BASE_ADDR + line_ofs;
                    cnt_d        = 10'd0;
                    pend_d       = 1'b0;
                    state_d      = StArm;
                end
            end
            StArm: begin
                if (!i_psram_busy) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (i_psram_busy) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (i_psram_done) begin
                    if ((cnt_q == LastWord) || pend_q || i_line_start) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q + 10'd1;
                        addr_d  = addr_q + 24'd2;
                        state_d = StArm;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= StIdle;
            disp_bank_q  <= 1'b0;
            fetch_bank_q <= 1'b1;
            addr_q       <= 24'd0;
            cnt_q        <= 10'd0;
            pend_q       <= 1'b0;
            pend_idx_q   <= 9'd0;
            underrun_q   <= 1'b0;
            line_ready_q <= 1'b0;
            rd_data_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            disp_bank_q  <= disp_bank_d;
            fetch_bank_q <= fetch_bank_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            underrun_q   <= underrun_d;
            line_ready_q <= line_ready_d;
            rd_data_q    <= rd_data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            buf_mem[wr_idx] <= i_psram_dout;
        end
    end

    assign o_psram_stb  = (state_q == StReq);
    assign o_psram_we   = 1'b0;
    assign o_psram_addr = addr_q;
    assign o_rd_data    = rd_data_q;
    assign o_fetching   = (state_q != StIdle);
    assign o_line_ready = line_ready_q;
    assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_psram_line_fetcher.sv
// Bench for psram_line_fetcher: behavioural PSRAM responder, table-driven read checks,
// hand-written corner sequences and randomized lines against an address/data reference model.
module tb_psram_line_fetcher;

    localparam int unsigned Wpl    = 320;
    localparam int unsigned Stride = 640;
    localparam int unsigned Base   = 0;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_line_start;
    logic [8:0]  i_line_index;
    logic        i_clr_err;
    logic        o_psram_stb;
    logic        o_psram_we;
    logic [23:0] o_psram_addr;
    logic        i_psram_busy;
    logic        i_psram_done;
    logic [15:0] i_psram_dout;
    logic [9:0]  i_rd_addr;
    logic [15:0] o_rd_data;
    logic        o_fetching;
    logic        o_line_ready;
    logic        o_underrun;

    psram_line_fetcher #(
        .WORDS_PER_LINE(Wpl),
        .BASE_ADDR     (24'(Base)),
        .LINE_STRIDE   (Stride)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_line_start (i_line_start),
        .i_line_index (i_line_index),
        .i_clr_err    (i_clr_err),
        .o_psram_stb  (o_psram_stb),
        .o_psram_we   (o_psram_we),
        .o_psram_addr (o_psram_addr),
        .i_psram_busy (i_psram_busy),
        .i_psram_done (i_psram_done),
        .i_psram_dout (i_psram_dout),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_fetching   (o_fetching),
        .o_line_ready (o_line_ready),
        .o_underrun   (o_underrun)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    int          lat        = 2;
    int          ack_delay  = 0;
    bit          busy_force = 1'b0;
    logic [23:0] addr_log[$];
    logic [23:0] cur;

    int   ready_cnt = 0;
    int   proto_err = 0;
    logic stb_prev  = 1'b0;
    logic busy_prev = 1'b0;

    int   bad, n0, hi, rc;
    int   idx, prev_idx, ra;

    typedef struct {
        logic [9:0]  rd;
        logic [15:0] exp;
    } rd_vec_t;
    rd_vec_t rtab [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // PSRAM word content as a function of its byte address.
    function automatic logic [15:0] pix(input logic [23:0] a);
        return 16'h0100 + a[16:1];
    endfunction

    function automatic logic [23:0] exp_addr(input int unsigned line, input int unsigned n);
        return 24'((Base + line * Stride + 2 * n) % 32'h0100_0000);
    endfunction

    task automatic start_line(input int line);
        @(negedge i_clk);
        i_line_index = 9'(line);
        i_line_start = 1'b1;
        @(negedge i_clk);
        i_line_start = 1'b0;
    endtask

    task automatic wait_ready(input int target, input int bound, input string name);
        int n = 0;
        while (ready_cnt < target && n < bound) begin
            @(negedge i_clk);
            n++;
        end
        chk(name, 32'(ready_cnt >= target), 32'd1);
    endtask

    task automatic wait_log(input int target, input int bound, input string name);
        int n = 0;
        while (addr_log.size() < target && n < bound) begin
            @(negedge i_clk);
            n++;
        end
        chk(name, 32'(addr_log.size() >= target), 32'd1);
    endtask

    task automatic check_line_addrs(input int line, input string name);
        int errs = 0;
        for (int n = 0; n < addr_log.size(); n++) begin
            if (addr_log[n] !== exp_addr(line, n)) errs++;
        end
        chk({name, "_words"}, addr_log.size(), Wpl);
        chk({name, "_addr_errs"}, errs, 0);
    endtask

    // Behavioural PSRAM: accepts a strobe after ack_delay cycles, busy for lat cycles, then done.
    initial begin
        i_psram_busy = 1'b0;
        i_psram_done = 1'b0;
        i_psram_dout = 16'h0000;
        forever begin
            @(posedge i_clk);
            #1;
            i_psram_done = 1'b0;
            if (busy_force) begin
                i_psram_busy = 1'b1;
            end else if (!i_psram_busy && o_psram_stb) begin
                cur = o_psram_addr;
                repeat (ack_delay) begin
                    @(posedge i_clk);
                    #1;
                end
                i_psram_busy = 1'b1;
                addr_log.push_back(cur);
                repeat (lat) begin
                    @(posedge i_clk);
                    #1;
                end
                i_psram_busy = 1'b0;
                i_psram_done = 1'b1;
                i_psram_dout = pix(cur);
            end else begin
                i_psram_busy = 1'b0;
            end
        end
    end

    always @(negedge i_clk) begin
        if (o_line_ready) ready_cnt <= ready_cnt + 1;
        if (o_psram_stb && !stb_prev && busy_prev) proto_err <= proto_err + 1;
        stb_prev  <= o_psram_stb;
        busy_prev <= i_psram_busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rtab[0] = '{rd: 10'd5,    exp: 16'h0105};
        rtab[1] = '{rd: 10'd0,    exp: 16'h0100};
        rtab[2] = '{rd: 10'd319,  exp: 16'h023F};
        rtab[3] = '{rd: 10'd320,  exp: 16'h0000};
        rtab[4] = '{rd: 10'd1023, exp: 16'h0000};
        rtab[5] = '{rd: 10'd160,  exp: 16'h01A0};

        i_rstn       = 1'b0;
        i_line_start = 1'b0;
        i_line_index = 9'd0;
        i_clr_err    = 1'b0;
        i_rd_addr    = 10'd0;
        repeat (3) @(negedge i_clk);
        chk("rst_stb", o_psram_stb, 0);
        chk("rst_we", o_psram_we, 0);
        chk("rst_addr", o_psram_addr, 0);
        chk("rst_fetching", o_fetching, 0);
        chk("rst_ready", o_line_ready, 0);
        chk("rst_underrun", o_underrun, 0);
        chk("rst_rd_data", o_rd_data, 0);
        i_rstn = 1'b1;
        @(negedge i_clk);

        // Line 0: full fetch with the address sequence 0..638.
        addr_log.delete();
        start_line(0);
        chk("t1_fetching", o_fetching, 1);
        wait_ready(1, 20000, "t1_ready");
        check_line_addrs(0, "t1");
        repeat (5) @(negedge i_clk);
        chk("t1_single_ready", ready_cnt, 1);
        chk("t1_idle", o_fetching, 0);

        // Line 3 fetch; line 0 is now displayed.
        addr_log.delete();
        start_line(3);
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            i_rd_addr = rtab[i].rd;
            @(negedge i_clk);
            chk($sformatf("tab_rd_%0d", rtab[i].rd), o_rd_data, rtab[i].exp);
        end
        chk("t2_we", o_psram_we, 0);
        wait_ready(2, 20000, "t2_ready");
        check_line_addrs(3, "t2");
        if (addr_log.size() == Wpl) begin
            chk("t2_first_addr", addr_log[0], 24'h000780);
            chk("t2_last_addr", addr_log[Wpl-1], 24'h0009FE);
        end

        // Busy held high before ARM; then stb/busy handshake timing.
        busy_force = 1'b1;
        ack_delay  = 3;
        repeat (2) @(negedge i_clk);
        start_line(1);
        bad = 0;
        repeat (50) begin
            @(negedge i_clk);
            if (o_psram_stb) bad++;
        end
        chk("busy_stb_low", bad, 0);
        chk("busy_fetching", o_fetching, 1);
        busy_force = 1'b0;
        n0 = 0;
        while (!o_psram_stb && n0 < 20) begin
            @(negedge i_clk);
            n0++;
        end
        chk("busy_stb_rise", o_psram_stb, 1);
        hi = 0;
        while (o_psram_stb && !i_psram_busy && hi < 20) begin
            hi++;
            @(negedge i_clk);
        end
        chk("stb_hold_cycles", hi, 3);
        chk("stb_high_at_busy", o_psram_stb & i_psram_busy, 1);
        @(negedge i_clk);
        chk("stb_drop", o_psram_stb, 0);
        ack_delay = 0;
        wait_ready(3, 30000, "t3_ready");

        // Underrun: second start during word 10 of line 2.
        lat = 4;
        addr_log.delete();
        start_line(2);
        wait_log(11, 2000, "ur_word10");
        i_line_index = 9'd7;
        i_line_start = 1'b1;
        @(negedge i_clk);
        i_line_start = 1'b0;
        chk("ur_set", o_underrun, 1);
        wait_log(12, 200, "ur_next_req");
        if (addr_log.size() >= 12) chk("ur_next_addr", addr_log[11], exp_addr(7, 0));
        chk("ur_no_ready", ready_cnt, 3);
        wait_ready(4, 30000, "ur_line7_ready");
        repeat (3) @(negedge i_clk);
        chk("ur_total_words", addr_log.size(), 11 + Wpl);
        chk("ur_one_ready", ready_cnt, 4);
        chk("ur_sticky", o_underrun, 1);
        @(negedge i_clk);
        i_clr_err = 1'b1;
        @(negedge i_clk);
        i_clr_err = 1'b0;
        chk("ur_clear", o_underrun, 0);

        // Start in the same cycle as the final done of line 4.
        lat = 2;
        addr_log.delete();
        start_line(4);
        wait_log(Wpl, 20000, "col_last_req");
        n0 = 0;
        while (!i_psram_done && n0 < 50) begin
            @(negedge i_clk);
            n0++;
        end
        chk("col_done_seen", i_psram_done, 1);
        i_line_index = 9'd6;
        i_line_start = 1'b1;
        @(negedge i_clk);
        i_line_start = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("col_ready", ready_cnt, 5);
        chk("col_no_underrun", o_underrun, 0);
        chk("col_banks_differ", 32'(dut.disp_bank_q != dut.fetch_bank_q), 1);
        i_rd_addr = 10'd5;
        @(negedge i_clk);
        chk("col_rd5", o_rd_data, 16'h0605);
        i_rd_addr = 10'd319;
        @(negedge i_clk);
        chk("col_rd319", o_rd_data, 16'h073F);
        wait_log(Wpl + 1, 200, "col_new_req");
        if (addr_log.size() > Wpl) chk("col_new_addr", addr_log[Wpl], 24'h000F00);
        wait_ready(6, 20000, "col_line6_ready");

        // Randomized lines: addresses and display reads against the reference model.
        prev_idx = 6;
        for (int k = 0; k < 4; k++) begin
            idx       = $urandom_range(0, 511);
            lat       = $urandom_range(1, 5);
            ack_delay = $urandom_range(0, 2);
            addr_log.delete();
            start_line(idx);
            for (int r = 0; r < 8; r++) begin
                ra = $urandom_range(0, 1023);
                @(negedge i_clk);
                i_rd_addr = 10'(ra);
                @(negedge i_clk);
                chk($sformatf("rand_rd_line%0d_a%0d", prev_idx, ra), o_rd_data,
                    (ra < Wpl) ? pix(exp_addr(prev_idx, ra)) : 16'h0000);
            end
            wait_ready(7 + k, 40000, "rand_ready");
            check_line_addrs(idx, $sformatf("rand_line%0d", idx));
            chk("rand_no_underrun", o_underrun, 0);
            prev_idx = idx;
        end

        // Set beats clear in the same cycle, then reset mid-line.
        lat       = 2;
        ack_delay = 0;
        addr_log.delete();
        start_line(5);
        wait_log(20, 2000, "rst_mid_line");
        @(negedge i_clk);
        i_line_index = 9'd5;
        i_line_start = 1'b1;
        i_clr_err    = 1'b1;
        @(negedge i_clk);
        i_line_start = 1'b0;
        i_clr_err    = 1'b0;
        chk("set_wins", o_underrun, 1);
        repeat (6) @(negedge i_clk);
        rc = ready_cnt;
        i_rstn = 1'b0;
        @(negedge i_clk);
        chk("rst_mid_stb", o_psram_stb, 0);
        chk("rst_mid_fetching", o_fetching, 0);
        chk("rst_mid_underrun", o_underrun, 0);
        chk("rst_mid_disp", dut.disp_bank_q, 0);
        chk("rst_mid_fetch", dut.fetch_bank_q, 1);
        repeat (5) @(negedge i_clk);
        i_rstn = 1'b1;
        repeat (10) @(negedge i_clk);
        chk("rst_no_ready", ready_cnt, rc);
        chk("rst_stays_idle", o_fetching, 0);
        chk("no_stb_while_busy", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
